// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central freeze/flush sequencer for a 5-stage pipeline. It merges the hazard,
// taken-branch and MEM-stage SRAM handshake into per-register freeze/flush
// controls. It also counts consecutive memory-wait cycles and latches a sticky
// timeout fault when the SRAM never answers.
//
// Optional feature: define STALL_STATS_EN to build the three 32-bit saturating
// statistics counters. When it is undefined, those ports are tied to zero.
//
// SRAM handshake: mem_req acts as "valid" and sram_ready as "ready". An access
// completes in any cycle where both are 1. A cycle with mem_req=1 and
// sram_ready=0 is a memory stall, and the whole pipeline holds. Dropping
// mem_req ends the stall without any transfer.
`timescale 1ns/1ps

module pipeline_stall_controller #(
  parameter int MAX_WAIT = 12,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        sram_ready,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        freeze_id_exe,
  output logic        freeze_exe_mem,
  output logic        freeze_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_exe,
  output logic        mem_timeout,
  output logic [1:0]  ctrl_state,
  output logic [31:0] hazard_stall_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Wait count reached on the last stall cycle that is still tolerated.
  localparam logic [WAIT_W-1:0] LP_LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_mem_timeout;
  logic              w_timeout_nxt;

  logic w_stall_mem;
  logic w_act_fault;
  logic w_act_mem;
  logic w_act_branch;
  logic w_act_hazard;

  assign w_stall_mem = mem_req & ~sram_ready;

  // Select exactly one action per cycle by priority: fault, memory stall,
  // branch, hazard. Reset suppresses every action.
  always_comb begin
    w_act_fault  = 1'b0;
    w_act_mem    = 1'b0;
    w_act_branch = 1'b0;
    w_act_hazard = 1'b0;
    if (!rst) begin
      if (r_state == ST_FAULT)  w_act_fault  = 1'b1;
      else if (w_stall_mem)     w_act_mem    = 1'b1;
      else if (branch_taken)    w_act_branch = 1'b1;
      else if (hazard)          w_act_hazard = 1'b1;
    end
  end

  // Map the chosen action onto the per-register controls. The hazard action
  // holds PC and IF/ID and injects a bubble into ID/EXE.
  always_comb begin
    freeze_pc      = w_act_fault | w_act_mem | w_act_hazard;
    freeze_if_id   = w_act_fault | w_act_mem | w_act_hazard;
    freeze_id_exe  = w_act_fault | w_act_mem;
    freeze_exe_mem = w_act_fault | w_act_mem;
    freeze_mem_wb  = w_act_fault | w_act_mem;
    flush_if_id    = w_act_branch;
    flush_id_exe   = w_act_branch | w_act_hazard;
  end

  // Next-state logic: track consecutive memory stalls and enter FAULT on the
  // MAX_WAIT-th one. FAULT is absorbing until reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    case (r_state)
      ST_RUN: begin
        if (w_stall_mem) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end else begin
          w_wait_nxt  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_stall_mem) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == LP_LAST_WAIT) begin
          w_state_nxt   = ST_FAULT;
          w_wait_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_FAULT: begin
        w_state_nxt   = ST_FAULT;
        w_timeout_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // State, wait counter and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign ctrl_state  = r_state;

`ifdef STALL_STATS_EN
  logic [31:0] r_hazard_stall_cnt;
  logic [31:0] r_mem_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counters of applied hazard, memory-stall and branch actions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hazard_stall_cnt <= '0;
      r_mem_stall_cnt    <= '0;
      r_flush_cnt        <= '0;
    end else begin
      if (w_act_hazard && (r_hazard_stall_cnt != 32'hFFFF_FFFF))
        r_hazard_stall_cnt <= r_hazard_stall_cnt + 32'd1;
      if (w_act_mem && (r_mem_stall_cnt != 32'hFFFF_FFFF))
        r_mem_stall_cnt <= r_mem_stall_cnt + 32'd1;
      if (w_act_branch && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hazard_stall_cnt = r_hazard_stall_cnt;
  assign mem_stall_cnt    = r_mem_stall_cnt;
  assign flush_cnt        = r_flush_cnt;
`else
  assign hazard_stall_cnt = 32'd0;
  assign mem_stall_cnt    = 32'd0;
  assign flush_cnt        = 32'd0;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central freeze/flush sequencer for the 5-stage pipeline. Each cycle it combines the hazard flag from hazard detection, the taken-branch flag from EXE, and the SRAM handshake seen by the MEM stage into per-stage-register freeze and flush controls. It tracks multi-cycle memory waits with a counter. If SRAM never answers, it latches a sticky timeout fault.

## Interface
- `MAX_WAIT`, default 12: number of consecutive memory-stall cycles tolerated before fault. Legal range is 2..2^WAIT_W-1.
- `WAIT_W`, default 4: width of the wait counter.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hazard`  in  1  data hazard from hazard detection; ID instruction must stall.
- `branch_taken`  in  1  EXE-stage branch resolved taken this cycle.
- `mem_req`  in  1  MEM-stage instruction has memory read or write enable.
- `sram_ready`  in  1  SRAM controller completes the access this cycle.
- `freeze_pc`  out  1  hold PC.
- `freeze_if_id`  out  1  hold IF/ID register.
- `freeze_id_exe`  out  1  hold ID/EXE register.
- `freeze_exe_mem`  out  1  hold EXE/MEM register.
- `freeze_mem_wb`  out  1  hold MEM/WB register.
- `flush_if_id`  out  1  load NOP into IF/ID.
- `flush_id_exe`  out  1  load NOP into ID/EXE (bubble).
- `mem_timeout`  out  1  sticky fault flag.
- `ctrl_state`  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 FAULT.
- `hazard_stall_cnt`, `mem_stall_cnt`, `flush_cnt`  out  32 each  statistics (see Configuration).

## Operation
- Internal signal: `stall_mem = mem_req & ~sram_ready`.
- Priority per cycle, highest first: FAULT, then stall_mem, then branch_taken, then hazard.
- **FAULT:** all five freezes = 1, both flushes = 0, `mem_timeout` = 1.
- **stall_mem (RUN or MEM_WAIT):**
  - All five freezes = 1, flushes = 0.
  - Any concurrent branch or hazard is ignored this cycle. The frozen instructions re-present them after release.
- **branch_taken:**
  - `flush_if_id` = `flush_id_exe` = 1.
  - All freezes = 0, so PC loads the target.
  - A concurrent hazard is discarded because the stalled instruction is squashed.
- **hazard:**
  - `freeze_pc` = `freeze_if_id` = 1.
  - `flush_id_exe` = 1 (bubble).
  - Other outputs 0.
- Otherwise all freeze/flush outputs are 0.
- State machine, evaluated at each edge, `rst` overriding all:
  - **RUN:** stall_mem → MEM_WAIT with `wait_cnt` = 1. Otherwise stay in RUN with `wait_cnt` = 0.
  - **MEM_WAIT, stall_mem = 0:** → RUN, `wait_cnt` = 0. The ready cycle itself is unfrozen, so the pipeline advances that cycle.
  - **MEM_WAIT, stall_mem = 1, `wait_cnt` == MAX_WAIT-1:** → FAULT.
  - **MEM_WAIT, stall_mem = 1, otherwise:** `wait_cnt`+1.
  - **FAULT:** absorbing; exits only via `rst`.
- If `mem_req` drops while in MEM_WAIT, that counts as stall_mem = 0, so the block returns to RUN.
- If `mem_req` and `sram_ready` are both 1 in RUN, the cycle has no stall and stays in RUN.

## Timing
- Freeze/flush outputs are combinational from inputs and current state. They take effect in the same cycle, with zero latency.
- `mem_timeout` and `ctrl_state` are registered.
- Fault occurs after exactly MAX_WAIT consecutive stall_mem cycles: `mem_timeout` rises after the MAX_WAIT-th edge.
- Reset values: `ctrl_state` = RUN, `wait_cnt` = 0, `mem_timeout` = 0, statistics = 0.
- While `rst` = 1, all freeze/flush outputs are forced to 0.
- Reset mid-wait or in FAULT returns to RUN on the next edge. Any pending wait is discarded.

## Configuration
- Macro `STALL_STATS_EN` defined:
  - `hazard_stall_cnt` increments each cycle the hazard action is applied.
  - `mem_stall_cnt` increments each cycle stall_mem freezes the pipeline.
  - `flush_cnt` increments each cycle a branch flush is applied.
  - All three saturate at 32'hFFFF_FFFF and are cleared by `rst`.
- Macro undefined: the three ports still exist but are tied to 0, and no counter logic is built.

## Test plan
- **Hazard:** `hazard`=1 for 2 cycles, no mem/branch → `freeze_pc`/`freeze_if_id`/`flush_id_exe` = 1 both cycles, `ctrl_state` stays 0; with stats, `hazard_stall_cnt` = 2.
- **Branch over hazard:** `branch_taken`=1 with `hazard`=1 → both flushes = 1, all freezes = 0; `flush_cnt` = 1.
- **Memory wait:** MAX_WAIT=4; `mem_req`=1, `sram_ready`=0 for 3 cycles then 1 → all freezes = 1 for 3 cycles, 0 on the ready cycle; `ctrl_state` goes 1 then 0; `mem_timeout` stays 0.
- **Timeout:** MAX_WAIT=4; `mem_req`=1, `sram_ready`=0 held → `mem_timeout`=1 and `ctrl_state`=2 after the 4th edge; freezes stay 1 even after `sram_ready`=1; `rst` pulse → RUN, `mem_timeout`=0.
- **Branch during memory stall:** `branch_taken`=1 during stall_mem → no flush while frozen; flush applied on the first unfrozen cycle.
- **Reset mid-wait:** `rst` during MEM_WAIT with `wait_cnt`=2 → outputs 0 while in reset; next stall restarts the count at 1 and needs 4 more stalled cycles to fault.
